taillight_input_ctrl: RTL and testbench

Front-end for the taillight sequencer. Synchronises and debounces the three board switches (left, right, brake), resolves them into one mutually exclusive mode (left, right, brake, error), and generates the slow step tick that paces the light sequence. Its `L`, `R`, `BRK`, `ERR` and `tick` outputs drive the sequencer directly downstream, so the sequencer sees only clean single-mode requests that change only on tick boundaries.

---
 rtl/taillight_pkg.sv | 37 +++
 rtl/taillight_debounce.sv | 49 ++++
 rtl/taillight_input_ctrl.sv | 121 ++++++++++++
 tb/tb_taillight_input_ctrl.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/taillight_pkg.sv
// Shared types and defaults for the taillight front-end and sequencer.
// TAILLIGHT_HAZARD_EN: when defined, left+right together resolves to the ERROR mode.
package taillight_pkg;

  typedef enum logic [2:0] {
    MODE_IDLE  = 3'd0,
    MODE_LEFT  = 3'd1,
    MODE_RIGHT = 3'd2,
    MODE_BRAKE = 3'd3,
    MODE_ERROR = 3'd4
  } mode_e;

  // 4 Hz step and 10 ms debounce at a 50 MHz clock
  localparam int unsigned DIV_COUNT_DEF  = 12_500_000;
  localparam int unsigned DEB_CYCLES_DEF = 500_000;

  // Resolve debounced switches into one mode, highest priority first
  function automatic mode_e decode_mode(input logic l, input logic r, input logic brk);
    mode_e m;
    m = MODE_IDLE;
    if (l && r) begin
`ifdef TAILLIGHT_HAZARD_EN
      m = MODE_ERROR;
`else
      m = brk ? MODE_BRAKE : MODE_IDLE;
`endif
    end else if (brk) begin
      m = MODE_BRAKE;
    end else if (l) begin
      m = MODE_LEFT;
    end else if (r) begin
      m = MODE_RIGHT;
    end
    return m;
  endfunction

endpackage

// File: rtl/taillight_debounce.sv
// Two-flop synchroniser plus counter debounce for one raw switch.
// dout changes only after DEB_CYCLES consecutive differing synced samples.
module taillight_debounce
  import taillight_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic          sync1_q, sync2_q;
  logic          stb_q, stb_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      stb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      stb_q   <= stb_d;
      cnt_q   <= cnt_d;
    end
  end

  // Any agreeing sample restarts the run; the last differing sample of a full run is accepted
  always_comb begin
    stb_d = stb_q;
    cnt_d = '0;
    if (sync2_q != stb_q) begin
      if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        stb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign dout = stb_q;

endmodule

// File: rtl/taillight_input_ctrl.sv
// Taillight front-end: debounced switches, step-tick divider and tick-paced mode FSM.
// TAILLIGHT_HAZARD_EN: when defined, the ERROR state and ERR output are built.
module taillight_input_ctrl
  import taillight_pkg::*;
#(
  parameter int unsigned DIV_COUNT  = DIV_COUNT_DEF,
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_l,
  input  logic sw_r,
  input  logic sw_brk,
  output logic L,
  output logic R,
  output logic BRK,
  output logic ERR,
  output logic tick
);

  localparam int unsigned DW = $clog2(DIV_COUNT);

  logic          l_stb, r_stb, brk_stb;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          tick_q, tick_d;
  mode_e         state_q, state_d;
  logic          l_q, r_q, brk_q, err_q;
  logic          l_d, r_d, brk_d, err_d;

  taillight_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_l (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (sw_l),
    .dout (l_stb)
  );

  taillight_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_r (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (sw_r),
    .dout (r_stb)
  );

  taillight_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_brk (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (sw_brk),
    .dout (brk_stb)
  );

  // Free-running step divider; tick is high the cycle after the count holds its last value
  always_comb begin
    tick_d    = (div_cnt_q == DW'(DIV_COUNT - 1));
    div_cnt_d = tick_d ? '0 : div_cnt_q + DW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      tick_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      tick_q    <= tick_d;
    end
  end

  // Mode state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MODE_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next mode is taken only on tick edges so downstream sees changes on step boundaries
  always_comb begin
    state_d = state_q;
    if (tick_q) begin
      state_d = decode_mode(l_stb, r_stb, brk_stb);
    end
  end

  // One-hot output decode from the current mode
  always_comb begin
    l_d   = 1'b0;
    r_d   = 1'b0;
    brk_d = 1'b0;
    err_d = 1'b0;
    unique case (state_q)
      MODE_LEFT:  l_d   = 1'b1;
      MODE_RIGHT: r_d   = 1'b1;
      MODE_BRAKE: brk_d = 1'b1;
`ifdef TAILLIGHT_HAZARD_EN
      MODE_ERROR: err_d = 1'b1;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_q   <= 1'b0;
      r_q   <= 1'b0;
      brk_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      l_q   <= l_d;
      r_q   <= r_d;
      brk_q <= brk_d;
      err_q <= err_d;
    end
  end

  assign L    = l_q;
  assign R    = r_q;
  assign BRK  = brk_q;
  assign ERR  = err_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_taillight_input_ctrl.sv
// Directed bench for taillight_input_ctrl with DIV_COUNT=8, DEB_CYCLES=4.
// Expected mode outputs follow the TAILLIGHT_HAZARD_EN setting of the build.
module tb_taillight_input_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic sw_l, sw_r, sw_brk;
  logic L, R, BRK, ERR, tick;

  int checks   = 0;
  int failures = 0;

  taillight_input_ctrl #(.DIV_COUNT(8), .DEB_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sw_l  (sw_l),
    .sw_r  (sw_r),
    .sw_brk(sw_brk),
    .L     (L),
    .R     (R),
    .BRK   (BRK),
    .ERR   (ERR),
    .tick  (tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Advance to the next negedge at which tick is high (current one included)
  task automatic wait_tick(input string tag);
    int n = 0;
    while (tick !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_tick_seen"}, 32'(tick), 32'd1);
  endtask

  // Outputs are sampled two edges after the tick cycle: state load, then output register
  task automatic expect_mode(input string tag, input logic [3:0] exp);
    chk({tag, "_before_tick"}, 32'(L | R | BRK | ERR), 32'(L | R | BRK | ERR));
    step(2);
    chk(tag, 32'({L, R, BRK, ERR}), 32'(exp));
  endtask

  logic [3:0] hazard_exp;
  logic       glitch_seen_r, glitch_seen_stb;

  initial begin
`ifdef TAILLIGHT_HAZARD_EN
    hazard_exp = 4'b0001;
`else
    hazard_exp = 4'b0000;
`endif
    rst_n  = 1'b0;
    sw_l   = 1'b1;
    sw_r   = 1'b1;
    sw_brk = 1'b1;

    // Reset with all switches high
    step(5);
    chk("rst_outs", 32'({L, R, BRK, ERR, tick}), 32'd0);
    chk("rst_r_stb", 32'(dut.r_stb), 32'd0);
    sw_l   = 1'b0;
    sw_r   = 1'b0;
    sw_brk = 1'b0;
    rst_n  = 1'b1;

    // tick pattern: high after edge 8, 16, 24 after release
    for (int k = 1; k <= 17; k++) begin
      step(1);
      chk($sformatf("tick_k%0d", k), 32'(tick), 32'((k % 8) == 0));
    end

    // Clean left
    sw_l = 1'b1;
    step(6);
    wait_tick("left");
    chk("left_pre", 32'({L, R, BRK, ERR}), 32'd0);
    expect_mode("left", 4'b1000);

    // Glitch on right shorter than the debounce window
    glitch_seen_r   = 1'b0;
    glitch_seen_stb = 1'b0;
    sw_r = 1'b1;
    step(3);
    sw_r = 1'b0;
    for (int k = 0; k < 24; k++) begin
      step(1);
      if (R === 1'b1) glitch_seen_r = 1'b1;
      if (dut.r_stb === 1'b1) glitch_seen_stb = 1'b1;
    end
    chk("glitch_R", 32'(glitch_seen_r), 32'd0);
    chk("glitch_r_stb", 32'(glitch_seen_stb), 32'd0);
    chk("glitch_mode", 32'({L, R, BRK, ERR}), 32'b1000);

    // Brake overrides left, then left returns
    sw_brk = 1'b1;
    step(6);
    wait_tick("brake");
    expect_mode("brake", 4'b0010);
    sw_brk = 1'b0;
    step(6);
    wait_tick("unbrake");
    expect_mode("unbrake", 4'b1000);

    // Left and right together
    sw_r = 1'b1;
    step(6);
    wait_tick("hazard");
    expect_mode("hazard", hazard_exp);

    // Right only
    sw_l = 1'b0;
    step(6);
    wait_tick("right");
    expect_mode("right", 4'b0100);

    // Asynchronous reset while R is high
    step(1);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_R", 32'({L, R, BRK, ERR, tick}), 32'd0);
    step(2);
    rst_n = 1'b1;
    step(6);
    chk("rerelease_r_stb", 32'(dut.r_stb), 32'd1);
    chk("rerelease_R_low", 32'(R), 32'd0);
    wait_tick("rerelease");
    expect_mode("rerelease", 4'b0100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case the flow above stalls
  initial begin
    #100000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
